// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : Request/response bundle between pipeline stages and pipe_ctrl.
//            The master side raises hazard, multi-cycle and exception
//            requests. The slave side (pipe_ctrl) returns the stall vector,
//            the flush/redirect signals and the status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    logic              stallreq_id;
    logic              ex_mc_start;
    logic [CNT_W-1:0]  ex_mc_len;
    logic              stallreq_mem;
    logic              excp_valid;
    logic [31:0]       excp_new_pc;

    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              ex_mc_busy;
    logic              ex_mc_done;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem,
               excp_valid, excp_new_pc,
        input  stall, flush, new_pc, ex_mc_busy, ex_mc_done, stall_cycles
    );

    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem,
               excp_valid, excp_new_pc,
        output stall, flush, new_pc, ex_mc_busy, ex_mc_done, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Central stall/flush sequencer for the 5-stage pipeline.
//            Arbitrates, highest first: exception flush, MEM bus wait,
//            EX multi-cycle occupancy, ID load-use. It also owns the EX
//            countdown counter and a stall-cycle performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,     // synchronous, active-low
    pipe_ctrl_if.slave  bus
);

    localparam logic [5:0]        STALL_NONE = 6'b000000;
    localparam logic [5:0]        STALL_ID   = 6'b000111;
    localparam logic [5:0]        STALL_EX   = 6'b001111;
    localparam logic [5:0]        STALL_MEM  = 6'b011111;
    localparam logic [CNT_W-1:0]  CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TWO    = CNT_W'(2);
    localparam logic [PERF_W-1:0] PERF_ONE   = PERF_W'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC      = 2'd1,
        FLUSHED = 2'd2
    } state_t;

    state_t            st, st_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [PERF_W-1:0] perf;

    logic [5:0]        stall_c;
    logic              flush_c;
    logic [31:0]       new_pc_c;
    logic              busy_c;
    logic              done_c;

    // State and countdown register; reset wins over everything, including
    // an in-flight multi-cycle op (no done pulse is produced for it).
    always_ff @(posedge clk) begin
        if (!rst) begin
            st  <= RUN;
            cnt <= CNT_ZERO;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
        end
    end

    // Arbitration: next state, next count and all combinational outputs.
    always_comb begin
        st_n     = st;
        cnt_n    = cnt;
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = 32'h0;
        busy_c   = 1'b0;
        done_c   = 1'b0;

        if (!rst) begin
            st_n  = RUN;
            cnt_n = CNT_ZERO;
        end else if (bus.excp_valid) begin
            // Exception overrides every other request in every state.
            flush_c  = 1'b1;
            new_pc_c = bus.excp_new_pc;
            st_n     = FLUSHED;
            cnt_n    = CNT_ZERO;
        end else begin
            unique case (st)
                RUN: begin
                    if (bus.ex_mc_start) begin
                        if (bus.ex_mc_len >= CNT_TWO) begin
                            busy_c = 1'b1;
                            st_n   = MC;
                            if (bus.stallreq_mem) begin
                                // Op is parked in EX but this cycle does
                                // not count toward its occupancy.
                                stall_c = STALL_MEM;
                                cnt_n   = bus.ex_mc_len;
                            end else begin
                                stall_c = STALL_EX;
                                cnt_n   = bus.ex_mc_len - CNT_ONE;
                            end
                        end else begin
                            // Zero/one-cycle op completes immediately.
                            done_c = 1'b1;
                            if (bus.stallreq_mem)
                                stall_c = STALL_MEM;
                            else if (bus.stallreq_id)
                                stall_c = STALL_ID;
                        end
                    end else if (bus.stallreq_mem) begin
                        stall_c = STALL_MEM;
                    end else if (bus.stallreq_id) begin
                        stall_c = STALL_ID;
                    end
                end

                MC: begin
                    busy_c = 1'b1;
                    if (bus.stallreq_mem) begin
                        stall_c = STALL_MEM;
                    end else if (cnt > CNT_ONE) begin
                        stall_c = STALL_EX;
                        cnt_n   = cnt - CNT_ONE;
                    end else begin
                        done_c = 1'b1;
                        cnt_n  = CNT_ZERO;
                        st_n   = RUN;
                        if (bus.stallreq_id)
                            stall_c = STALL_ID;
                    end
                end

                FLUSHED: begin
                    // ID/EX contents are stale after a flush; only the bus
                    // wait from MEM is still meaningful.
                    if (bus.stallreq_mem)
                        stall_c = STALL_MEM;
                    st_n = RUN;
                end

                default: begin
                    st_n  = RUN;
                    cnt_n = CNT_ZERO;
                end
            endcase
        end
    end

    // Performance counter of cycles with any stall asserted; wraps freely.
    always_ff @(posedge clk) begin
        if (!rst)
            perf <= '0;
        else if (stall_c != STALL_NONE)
            perf <= perf + PERF_ONE;
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_c;
    assign bus.new_pc       = new_pc_c;
    assign bus.ex_mc_busy   = busy_c;
    assign bus.ex_mc_done   = done_c;
    assign bus.stall_cycles = perf;

endmodule
`default_nettype wire
